alu_issue_stage: RTL
====================

# alu_issue_stage

Operand issue and result-capture stage that sits directly upstream and downstream of the combinational logic unit (`module_logic`). It accepts operations (`a`, `b`, `op`, `tag`) through a valid/ready handshake and buffers them in a small FIFO. It presents the FIFO head to the logic unit and registers the unit's result, with status flags, into a valid/ready output slot. It gives the combinational unit a registered, back-pressurable pipeline boundary on both sides.

## Interface
- `WIDTH`, 32: operand/result width; power of two, ≥ 8.
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `TAG_W`, 4: width of the user tag carried with each operation.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: upstream offers an operation.
- `in_ready` output 1: stage can accept; equals `count < DEPTH`.
- `in_a` input WIDTH: operand A.
- `in_b` input WIDTH: operand B.
- `in_op` input 5: opcode.
- `in_tag` input TAG_W: user tag.
- `alu_a` output WIDTH: to logic unit; FIFO-head A, or 0 when the FIFO is empty.
- `alu_b` output WIDTH: to logic unit; FIFO-head B, shift-masked, or 0 when empty.
- `alu_op` output 5: to logic unit; FIFO-head op, or 5'b00000 when empty.
- `alu_result` input WIDTH: combinational result from the logic unit.
- `out_valid` output 1: result slot holds a result.
- `out_ready` input 1: downstream consumes the result.
- `out_result` output WIDTH: registered result.
- `out_tag` output TAG_W: tag of the registered result.
- `out_zero` output 1: `out_result == 0`.
- `out_illegal` output 1: opcode was outside 1..12.
- `count` output $clog2(DEPTH)+1: FIFO occupancy.
- `stat_issued` output 16: issued-operation counter (see Configuration).
- `stat_illegal` output 16: illegal-operation counter (see Configuration).

## Operation
- Push: `in_valid && in_ready` writes `{a, b, op, tag}` at the write pointer. Pointers wrap modulo DEPTH.
- Legal opcodes are 5'd1..5'd12:
  - AND=1, OR=2, NOT=3, XOR=4, NAND=5, NOR=6
  - SRL=7, SRA=8, SLL=9
  - EQ=10, GT=11, LT=12
- Shift masking: for ops 7, 8 and 9, `alu_b` = head B & (WIDTH-1). All other ops pass head B unchanged.
- Issue condition: `issue = (count != 0) && (!out_valid || out_ready)`.
- On issue, the output slot is loaded in one cycle:
  - `out_result` ← `alu_result` for a legal op, or 0 for an illegal op.
  - `out_tag` ← head tag; `out_illegal` ← (op ∉ 1..12); `out_zero` ← (loaded result == 0).
  - `out_valid` ← 1, and the head is popped.
- Clearing: if `out_valid && out_ready` and there is no issue, `out_valid` ← 0. `out_result`, `out_tag` and the flags hold their last values.
- Simultaneous push and pop: `count` is unchanged and both pointers advance.
- Full (`count == DEPTH`): `in_ready` = 0. There is no same-cycle pass-through on full.
- Empty: no issue occurs, and `alu_*` are driven to zero.
- Ordering: strictly FIFO; results leave in acceptance order.

## Timing
- Reset values, all 0: pointers, `count`, `out_valid`, `out_result`, `out_tag`, `out_zero`, `out_illegal`, stat counters.
- After reset, `in_ready` = 1.
- Asserting `rst` mid-operation discards all buffered entries and any pending result on the next edge.
- Latency:
  - Accept at edge N makes the entry the head after edge N.
  - `out_valid` rises after edge N+1 when the output slot is free.
  - Minimum is 2 cycles from input handshake to output valid.
- Throughput is 1 operation/cycle with `out_ready` held high.
- Output stall: with `out_ready` low, `out_result`, `out_tag` and the flags are stable while `out_valid` = 1. The FIFO fills to DEPTH, then `in_ready` drops.
- `in_ready` and `alu_*` depend only on registered state.
- The `alu_result` → output slot path is combinational through the logic unit within one cycle.

## Configuration
- `ALU_ISSUE_STATS_EN` defined:
  - `stat_issued` increments on every issue.
  - `stat_illegal` increments on every issue with an illegal op.
  - Both are 16-bit, saturate at 16'hFFFF, and clear on `rst`.
- `ALU_ISSUE_STATS_EN` undefined: both ports are tied to 0 and no counter logic exists.

## Test plan
- Reset, then push AND with a=32'hAAAA_AAAA, b=32'hFFFF_0000, tag=3, `out_ready` = 1 → `out_valid` 2 cycles after accept, with `out_result` = 32'hAAAA_0000, `out_tag` = 3, `out_zero` = 0.
- Push SRA with a=32'hFFFF_FF00, b=32'h0000_0024 → `alu_b` = 4, `out_result` = 32'hFFFF_FFF0.
- Hold `out_ready` = 0 and push 5 operations (DEPTH=4):
  - 1 lands in the slot, 4 fill the FIFO, then `in_ready` = 0 and `count` = 4.
  - Raise `out_ready` → results drain in order, one per cycle.
- Push op=5'b11111, then EQ with a=b=100 → first result is 0 with `out_illegal` = 1 and `out_zero` = 1; second result = 1 with `out_illegal` = 0.
- Fill the FIFO to 3 entries, assert `rst` for 1 cycle → `count` = 0, `out_valid` = 0, no further outputs.
- With `ALU_ISSUE_STATS_EN` defined, issue 10 operations, 2 of them illegal → `stat_issued` = 10, `stat_illegal` = 2.

Source files
------------

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - operand issue FIFO and registered result slot around the combinational logic unit
// Optional statistics counters are built only when ALU_ISSUE_STATS_EN is defined.
module alu_issue_stage #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  input  logic [4:0]               in_op,
  input  logic [TAG_W-1:0]         in_tag,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [4:0]               alu_op,
  input  logic [WIDTH-1:0]         alu_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_result,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_zero,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              stat_issued,
  output logic [15:0]              stat_illegal
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]       FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [WIDTH-1:0]  SHAMT_MASK = WIDTH'(WIDTH - 1);
  localparam logic [4:0]        OP_FIRST   = 5'd1;
  localparam logic [4:0]        OP_LAST    = 5'd12;
  localparam logic [4:0]        OP_SRL     = 5'd7;
  localparam logic [4:0]        OP_SLL     = 5'd9;

  logic [WIDTH-1:0] a_mem   [DEPTH];
  logic [WIDTH-1:0] b_mem   [DEPTH];
  logic [4:0]       op_mem  [DEPTH];
  logic [TAG_W-1:0] tag_mem [DEPTH];

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  logic             empty;
  logic             push;
  logic             issue;
  logic [WIDTH-1:0] head_a;
  logic [WIDTH-1:0] head_b;
  logic [4:0]       head_op;
  logic [TAG_W-1:0] head_tag;
  logic             head_legal;
  logic             head_shift;
  logic [WIDTH-1:0] loaded_result;

  assign empty    = (count == '0);
  assign in_ready = (count < FULL_COUNT);
  assign push     = in_valid && in_ready;
  assign issue    = !empty && (!out_valid || out_ready);

  assign head_a   = a_mem[rd_ptr];
  assign head_b   = b_mem[rd_ptr];
  assign head_op  = op_mem[rd_ptr];
  assign head_tag = tag_mem[rd_ptr];

  assign head_legal = (head_op >= OP_FIRST) && (head_op <= OP_LAST);
  assign head_shift = (head_op >= OP_SRL) && (head_op <= OP_SLL);

  // Present the FIFO head to the logic unit; zeros when empty, shift amounts masked to the operand width.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = 5'b00000;
    if (!empty) begin
      alu_a  = head_a;
      alu_b  = head_shift ? (head_b & SHAMT_MASK) : head_b;
      alu_op = head_op;
    end
  end

  // Illegal opcodes never let the logic unit's output through.
  assign loaded_result = head_legal ? alu_result : '0;

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      a_mem[wr_ptr]   <= in_a;
      b_mem[wr_ptr]   <= in_b;
      op_mem[wr_ptr]  <= in_op;
      tag_mem[wr_ptr] <= in_tag;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; count tracks push/pop balance.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (issue) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, issue})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Output slot: load on issue, drop valid when consumed; data and flags hold after the drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_tag     <= '0;
      out_zero    <= 1'b0;
      out_illegal <= 1'b0;
    end else if (issue) begin
      out_valid   <= 1'b1;
      out_result  <= loaded_result;
      out_tag     <= head_tag;
      out_zero    <= (loaded_result == '0);
      out_illegal <= !head_legal;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] issued_cnt;
  logic [15:0] illegal_cnt;

  // Saturating issue and illegal-issue counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      issued_cnt  <= '0;
      illegal_cnt <= '0;
    end else if (issue) begin
      if (issued_cnt != 16'hFFFF) begin
        issued_cnt <= issued_cnt + 16'd1;
      end
      if (!head_legal && (illegal_cnt != 16'hFFFF)) begin
        illegal_cnt <= illegal_cnt + 16'd1;
      end
    end
  end

  assign stat_issued  = issued_cnt;
  assign stat_illegal = illegal_cnt;
`else
  assign stat_issued  = 16'd0;
  assign stat_illegal = 16'd0;
`endif

endmodule
